// File: rtl/fwrisc_alu_mc.sv
// fwrisc_alu_mc: multi-cycle ALU with iterative shifter and valid/ready on both sides.
// Compare flags are captured at accept and held with the result until the next op.
module fwrisc_alu_mc #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             eqz,
  output logic             ltu
);

  localparam int unsigned AW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_CLR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [AW-1:0]    remaining;
  logic [3:0]       op_q;

  logic [WIDTH-1:0] alu_c;
  logic [WIDTH-1:0] shifted_c;
  logic [AW-1:0]    step_c;
  logic [AW-1:0]    amt_c;
  logic             is_shift_c;

  // Single-cycle result for all non-shift ops; unused codes behave as XOR.
  always_comb begin
    alu_c = op_a ^ op_b;
    case (op)
      OP_ADD:  alu_c = op_a + op_b;
      OP_SUB:  alu_c = op_a - op_b;
      OP_AND:  alu_c = op_a & op_b;
      OP_OR:   alu_c = op_a | op_b;
      OP_CLR:  alu_c = op_a & ~op_b;
      OP_SLT:  alu_c = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_c = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      default: alu_c = op_a ^ op_b;
    endcase
  end

  // Shift decode at accept and one iteration of the shifter.
  always_comb begin
    is_shift_c = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    amt_c      = op_b[AW-1:0];
    step_c     = (remaining < AW'(SHIFT_STEP)) ? remaining : AW'(SHIFT_STEP);
    shifted_c  = work >> step_c;
    case (op_q)
      OP_SLL:  shifted_c = work << step_c;
      // Arithmetic shift of the working value keeps the original sign bit in the MSB.
      OP_SRA:  shifted_c = WIDTH'($signed(work) >>> step_c);
      default: shifted_c = work >> step_c;
    endcase
  end

  // Control FSM with registered result, flags and handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      carry     <= 1'b0;
      eqz       <= 1'b0;
      ltu       <= 1'b0;
      work      <= '0;
      remaining <= '0;
      op_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry    <= $signed(op_b) > $signed(op_a);
            eqz      <= op_b == op_a;
            ltu      <= op_b > op_a;
            op_q     <= op;
            in_ready <= 1'b0;
            if (is_shift_c && (amt_c != '0)) begin
              work      <= op_a;
              remaining <= amt_c;
              state     <= SHIFT;
            end else begin
              out       <= is_shift_c ? op_a : alu_c;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          work      <= shifted_c;
          remaining <= remaining - step_c;
          if (remaining == step_c) begin
            out       <= shifted_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
